epmp_dbg_ctrl: RTL and testbench
================================

# epmp_dbg_ctrl

Run/step/breakpoint controller for the EPMP core, directly upstream of the CPU's debug inputs. Accepts one-cycle commands from a host (switches, UART bridge or testbench), drives the core's `Debug_Run`/`Debug_Mode` inputs, and observes the core's `Debug_PC`/`Debug_State`. It halts the core at a programmable PC breakpoint and counts executed core cycles.

## Interface
Parameters:
- `FETCH_STATE`, default 5'd0: `Debug_State` value that marks an instruction boundary (fetch state).

Ports:
- `clk`  in  1: single system clock, rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Cmd_Valid`  in  1: command strobe, one command per asserted cycle.
- `Cmd`  in  3: 000 NOP, 001 RUN, 010 HALT, 011 STEP_C, 100 STEP_I, 101 SET_BP, 110 CLR_BP, 111 CLR_CNT.
- `Cmd_Data`  in  16: breakpoint address for SET_BP.
- `Debug_PC`  in  16: core PC.
- `Debug_State`  in  5: core control-unit state.
- `Debug_Run`  out  1: core advances one micro-state on each clock where this is high.
- `Debug_Mode`  out  2: 00 HALT, 01 RUN, 10 STEP_C, 11 STEP_I (mirrors FSM state).
- `Halted`  out  1: FSM in HALT.
- `Bp_Hit`  out  1: one-cycle pulse when a breakpoint stops the core.
- `Cmd_Err`  out  1: one-cycle pulse, registered, when a command is rejected.
- `Cycle_Count`  out  16: number of cycles with `Debug_Run`=1.

## Operation
- FSM states: HALT, RUN, STEP_C, STEP_I. Reset value is HALT. While `Reset`=1: `Debug_Run`=0, `Debug_Mode`=00, `Halted`=1, `Bp_Hit`=0, `Cmd_Err`=0, `Cycle_Count`=0, breakpoint invalid, address 0.
- HALT:
  - RUN goes to RUN.
  - STEP_C goes to STEP_C.
  - STEP_I goes to STEP_I.
  - HALT and NOP: stay.
- RUN, STEP_C, STEP_I:
  - HALT goes to HALT.
  - RUN, STEP_C and STEP_I are rejected: `Cmd_Err` pulses, state is unchanged.
- SET_BP, CLR_BP and CLR_CNT are accepted in every state.
  - SET_BP: `bp_addr`=`Cmd_Data`, `bp_valid`=1.
  - CLR_BP: `bp_valid`=0.
  - CLR_CNT: `Cycle_Count`=0. This has priority over an increment in the same cycle.
- `first` flag: set on entry to RUN or STEP_I, cleared after one cycle in that state. It masks the boundary compare, so resuming from a breakpoint, or stepping from a fetch state, makes progress.
- `boundary` = (`Debug_State`==`FETCH_STATE`) & ~`first`.
- `bp_match` = `bp_valid` & `boundary` & (`Debug_PC`==`bp_addr`).
- `Debug_Run` is combinational:
  - RUN: ~`bp_match`.
  - STEP_C: 1.
  - STEP_I: ~`boundary`.
  - HALT: 0.
- Exits to HALT:
  - RUN leaves on `bp_match` and pulses `Bp_Hit` in the match cycle (combinational, 1 cycle).
  - STEP_C always leaves after exactly one cycle.
  - STEP_I leaves on `boundary`.
  - In STEP_I, `bp_match` also pulses `Bp_Hit`.
- `Cycle_Count`: increments on every clock with `Debug_Run`=1 and saturates at 16'hFFFF.

## Timing
- Command sampled at edge k; new state and `Debug_Mode` are visible after edge k; `Debug_Run` can first be high in cycle k+1.
- Breakpoint stop has zero latency: the core never advances past the fetch state whose PC equals `bp_addr`.
- STEP_C produces exactly one `Debug_Run` cycle.
- STEP_I produces N ≥ 1 `Debug_Run` cycles, ending at the next fetch state.
- Simultaneous events:
  - HALT command together with `bp_match`: go to HALT and still pulse `Bp_Hit`.
  - SET_BP issued in RUN takes effect from the next cycle.
  - `Reset` overrides `Cmd_Valid`.
  - Reset mid-run or mid-step returns to HALT at the next edge; the counter clears.
- `Cmd_Err` is registered and rises one cycle after the rejected command.

## Configuration
- `EPMP_DBG_BP_EN` defined: breakpoint register, comparator and `Bp_Hit` are built as described.
- `EPMP_DBG_BP_EN` undefined:
  - No breakpoint logic; `bp_match` is constant 0 and `Bp_Hit` is tied 0.
  - SET_BP and CLR_BP are accepted as no-ops without `Cmd_Err`.
  - RUN stops only on the HALT command.

## Test plan
- Reset, then idle 5 cycles -> `Halted`=1, `Debug_Mode`=00, `Debug_Run`=0, `Cycle_Count`=0.
- STEP_C from HALT -> `Debug_Run` high for exactly 1 cycle, `Cycle_Count`=1, back in HALT.
- STEP_I with a core model cycling `Debug_State` 0,1,2,3,0 -> `Debug_Run` high 4 cycles, halts with `Debug_State`=0, `Cycle_Count`=4.
- SET_BP 16'h0012, then RUN, PC reaches 0x0012 at a fetch state -> `Bp_Hit` pulse, `Debug_Run`=0 in the same cycle, `Halted`=1. A second RUN proceeds past 0x0012 without re-hitting.
- In RUN, issue STEP_C -> `Cmd_Err`=1 one cycle later, state stays RUN. Then HALT -> `Halted`=1 the next cycle.
- Force `Cycle_Count` to 16'hFFFF during RUN -> value holds at FFFF. CLR_CNT in the same cycle as an increment -> 0.

Source files
------------

// File: rtl/epmp_dbg_ctrl.sv
// epmp_dbg_ctrl: run/step/breakpoint controller sitting in front of the EPMP
// core debug inputs. Host commands select HALT/RUN/STEP_C/STEP_I; the block
// gates Debug_Run, stops at an optional PC breakpoint and counts run cycles.
// Optional feature macro: EPMP_DBG_BP_EN builds the breakpoint register,
// comparator and Bp_Hit; without it bp_match is 0 and Bp_Hit is tied low.
`timescale 1ns/1ps
module epmp_dbg_ctrl #(
  parameter logic [4:0] FETCH_STATE = 5'd0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Cmd_Valid,
  input  logic [2:0]  Cmd,
  input  logic [15:0] Cmd_Data,
  input  logic [15:0] Debug_PC,
  input  logic [4:0]  Debug_State,
  output logic        Debug_Run,
  output logic [1:0]  Debug_Mode,
  output logic        Halted,
  output logic        Bp_Hit,
  output logic        Cmd_Err,
  output logic [15:0] Cycle_Count
);

  typedef enum logic [1:0] {
    ST_HALT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP_C = 2'b10,
    ST_STEP_I = 2'b11
  } state_t;

  localparam logic [2:0] CMD_RUN     = 3'b001;
  localparam logic [2:0] CMD_HALT    = 3'b010;
  localparam logic [2:0] CMD_STEP_C  = 3'b011;
  localparam logic [2:0] CMD_STEP_I  = 3'b100;
  localparam logic [2:0] CMD_CLR_CNT = 3'b111;

  state_t      state_r;
  state_t      cmd_next_s;
  state_t      state_next_s;
  logic        first_r;
  logic        cmd_err_r;
  logic        err_next_s;
  logic [15:0] cycle_count_r;
  logic        boundary_s;
  logic        bp_match_s;
  logic        run_s;
  logic        clr_cnt_s;

  // first masks the fetch-state compare for one cycle after entering RUN/STEP_I
  assign boundary_s = (Debug_State == FETCH_STATE) & ~first_r;
  assign clr_cnt_s  = Cmd_Valid & (Cmd == CMD_CLR_CNT);

`ifdef EPMP_DBG_BP_EN
  localparam logic [2:0] CMD_SET_BP = 3'b101;
  localparam logic [2:0] CMD_CLR_BP = 3'b110;

  logic        bp_valid_r;
  logic [15:0] bp_addr_r;

  // Breakpoint register: SET_BP loads address and arms, CLR_BP disarms
  always_ff @(posedge clk) begin
    if (Reset) begin
      bp_valid_r <= 1'b0;
      bp_addr_r  <= 16'h0000;
    end else if (Cmd_Valid && (Cmd == CMD_SET_BP)) begin
      bp_valid_r <= 1'b1;
      bp_addr_r  <= Cmd_Data;
    end else if (Cmd_Valid && (Cmd == CMD_CLR_BP)) begin
      bp_valid_r <= 1'b0;
    end else begin
      bp_valid_r <= bp_valid_r;
      bp_addr_r  <= bp_addr_r;
    end
  end

  assign bp_match_s = bp_valid_r & boundary_s & (Debug_PC == bp_addr_r);
`else
  logic unused_bp_inputs_s;
  assign unused_bp_inputs_s = ^{Cmd_Data, Debug_PC};
  assign bp_match_s         = 1'b0;
`endif

  // Command decode: transitions out of HALT, HALT from anywhere, rejects
  always_comb begin
    cmd_next_s = state_r;
    err_next_s = 1'b0;
    if (Cmd_Valid) begin
      case (Cmd)
        CMD_RUN, CMD_STEP_C, CMD_STEP_I: begin
          if (state_r == ST_HALT) begin
            case (Cmd)
              CMD_RUN:    cmd_next_s = ST_RUN;
              CMD_STEP_C: cmd_next_s = ST_STEP_C;
              default:    cmd_next_s = ST_STEP_I;
            endcase
          end else begin
            err_next_s = 1'b1;
          end
        end
        CMD_HALT: cmd_next_s = ST_HALT;
        default:  cmd_next_s = state_r;
      endcase
    end else begin
      cmd_next_s = state_r;
    end
  end

  // Automatic exits to HALT override the command-driven next state
  always_comb begin
    state_next_s = cmd_next_s;
    case (state_r)
      ST_RUN: begin
        if (bp_match_s) state_next_s = ST_HALT;
        else            state_next_s = cmd_next_s;
      end
      ST_STEP_C: state_next_s = ST_HALT;
      ST_STEP_I: begin
        if (boundary_s) state_next_s = ST_HALT;
        else            state_next_s = cmd_next_s;
      end
      default: state_next_s = cmd_next_s;
    endcase
  end

  // Core advance enable per mode (zero-latency breakpoint stop)
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_RUN:    run_s = ~bp_match_s;
      ST_STEP_C: run_s = 1'b1;
      ST_STEP_I: run_s = ~boundary_s;
      default:   run_s = 1'b0;
    endcase
  end

  // FSM state, first flag and registered command-error pulse
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r   <= ST_HALT;
      first_r   <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      first_r   <= ((state_next_s == ST_RUN) || (state_next_s == ST_STEP_I)) &&
                   (state_next_s != state_r);
      cmd_err_r <= err_next_s;
    end
  end

  // Saturating run-cycle counter; CLR_CNT wins over an increment
  always_ff @(posedge clk) begin
    if (Reset || clr_cnt_s) begin
      cycle_count_r <= 16'h0000;
    end else if (run_s && (cycle_count_r != 16'hFFFF)) begin
      cycle_count_r <= cycle_count_r + 16'd1;
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end

  assign Debug_Run   = run_s & ~Reset;
  assign Bp_Hit      = bp_match_s & ((state_r == ST_RUN) | (state_r == ST_STEP_I)) & ~Reset;
  assign Debug_Mode  = state_r;
  assign Halted      = (state_r == ST_HALT);
  assign Cmd_Err     = cmd_err_r;
  assign Cycle_Count = cycle_count_r;

endmodule

// File: tb/tb_epmp_dbg_ctrl.sv
// Self-checking bench for epmp_dbg_ctrl: directed steps followed by a random
// phase, every cycle compared against a behavioural model of the debug rules
// driving a small 4-micro-state core model (state 0 is the fetch state).
`timescale 1ns/1ps
module tb_epmp_dbg_ctrl;

`ifdef EPMP_DBG_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Cmd_Valid = 1'b0;
  logic [2:0]  Cmd = 3'd0;
  logic [15:0] Cmd_Data = 16'd0;
  logic [15:0] Debug_PC = 16'd0;
  logic [4:0]  Debug_State = 5'd0;
  logic        Debug_Run;
  logic [1:0]  Debug_Mode;
  logic        Halted;
  logic        Bp_Hit;
  logic        Cmd_Err;
  logic [15:0] Cycle_Count;

  int checks = 0;
  int failures = 0;

  // model state: mode 0 HALT, 1 RUN, 2 STEP_C, 3 STEP_I
  int          m_mode = 0;
  bit          m_first = 1'b0;
  bit          m_bpv = 1'b0;
  logic [15:0] m_bpa = 16'd0;
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  bit          m_known = 1'b0;
  // core model
  int          core_st = 0;
  logic [15:0] core_pc = 16'd0;
  // observation counters
  int          run_cycles = 0;
  int          bp_hits = 0;

  always #5 clk = ~clk;

  epmp_dbg_ctrl #(.FETCH_STATE(5'd0)) dut (
    .clk(clk), .Reset(Reset), .Cmd_Valid(Cmd_Valid), .Cmd(Cmd),
    .Cmd_Data(Cmd_Data), .Debug_PC(Debug_PC), .Debug_State(Debug_State),
    .Debug_Run(Debug_Run), .Debug_Mode(Debug_Mode), .Halted(Halted),
    .Bp_Hit(Bp_Hit), .Cmd_Err(Cmd_Err), .Cycle_Count(Cycle_Count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare mid-cycle, update models at posedge
  task automatic cycle(input bit rst, input bit cv, input logic [2:0] c, input logic [15:0] d);
    bit bnd, match, run, hit, clr;
    int nm;
    @(negedge clk);
    Reset = rst; Cmd_Valid = cv; Cmd = c; Cmd_Data = d;
    Debug_State = 5'(core_st); Debug_PC = core_pc;
    #1;
    bnd   = (core_st == 0) && !m_first;
    match = BP_EN && m_bpv && bnd && (core_pc == m_bpa);
    case (m_mode)
      1: run = !match;
      2: run = 1'b1;
      3: run = !bnd;
      default: run = 1'b0;
    endcase
    hit = match && (m_mode == 1 || m_mode == 3);
    if (rst) begin run = 1'b0; hit = 1'b0; end
    if (m_known) begin
      check("debug_run", 32'(Debug_Run), 32'(run));
      check("bp_hit", 32'(Bp_Hit), 32'(hit));
      check("debug_mode", 32'(Debug_Mode), 32'(m_mode));
      check("halted", 32'(Halted), 32'(m_mode == 0));
      check("cmd_err", 32'(Cmd_Err), 32'(m_err));
      check("cycle_count", 32'(Cycle_Count), 32'(m_cnt));
    end
    if (Debug_Run === 1'b1) run_cycles++;
    if (Bp_Hit === 1'b1) bp_hits++;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_first = 1'b0; m_bpv = 1'b0; m_bpa = 16'd0;
      m_cnt = 0; m_err = 1'b0; m_known = 1'b1;
    end else begin
      nm = m_mode; m_err = 1'b0; clr = 1'b0;
      if (cv) begin
        case (c)
          3'd1, 3'd3, 3'd4: begin
            if (m_mode == 0) nm = (c == 3'd1) ? 1 : (c == 3'd3) ? 2 : 3;
            else m_err = 1'b1;
          end
          3'd2: nm = 0;
          3'd5: if (BP_EN) begin m_bpv = 1'b1; m_bpa = d; end
          3'd6: m_bpv = 1'b0;
          3'd7: clr = 1'b1;
          default: ;
        endcase
      end
      if (m_mode == 1 && match) nm = 0;
      if (m_mode == 2) nm = 0;
      if (m_mode == 3 && bnd) nm = 0;
      m_first = (nm == 1 || nm == 3) && (nm != m_mode);
      m_mode = nm;
      if (clr) m_cnt = 0;
      else if (run && m_cnt < 65535) m_cnt++;
    end
    if (run) begin
      core_st = (core_st + 1) % 4;
      if (core_st == 0) core_pc = core_pc + 16'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 16'd0);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [15:0] d);
    cycle(1'b0, 1'b1, c, d);
  endtask

  initial begin
    int hits_before;
    int budget;
    // reset then idle
    cycle(1'b1, 1'b0, 3'd0, 16'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'd0);
    idle(5);
    #1;
    check("rst_halted", 32'(Halted), 32'd1);
    check("rst_mode", 32'(Debug_Mode), 32'd0);
    check("rst_count", 32'(Cycle_Count), 32'd0);

    // STEP_C: exactly one run cycle
    run_cycles = 0;
    cmd(3'd3, 16'd0);
    idle(4);
    #1;
    check("stepc_runs", 32'(run_cycles), 32'd1);
    check("stepc_count", 32'(Cycle_Count), 32'd1);
    check("stepc_halted", 32'(Halted), 32'd1);

    // align core to the fetch state, then STEP_I from fetch
    budget = 0;
    while (core_st != 0 && budget < 10) begin
      cmd(3'd3, 16'd0);
      idle(1);
      budget++;
    end
    check("align_fetch", 32'(core_st), 32'd0);
    cmd(3'd7, 16'd0);
    run_cycles = 0;
    cmd(3'd4, 16'd0);
    idle(8);
    #1;
    check("stepi_runs", 32'(run_cycles), 32'd4);
    check("stepi_state", 32'(Debug_State), 32'd0);
    check("stepi_count", 32'(Cycle_Count), 32'd4);
    check("stepi_halted", 32'(Halted), 32'd1);

    // breakpoint at 0x0012, then resume past it
    cmd(3'd5, 16'h0012);
    hits_before = bp_hits;
    cmd(3'd1, 16'd0);
    budget = 0;
    while (bp_hits == hits_before && budget < 200) begin
      idle(1);
      budget++;
    end
    #1;
    check("bp_hit_count", 32'(bp_hits - hits_before), 32'(BP_EN));
    check("bp_halted", 32'(Halted), 32'(BP_EN));
    if (BP_EN) check("bp_stop_pc", 32'(Debug_PC), 32'h0012);
    cmd(3'd2, 16'd0);
    cmd(3'd1, 16'd0);
    idle(20);
    #1;
    check("bp_no_rehit", 32'(bp_hits - hits_before), 32'(BP_EN));
    check("resume_running", 32'(Debug_Mode), 32'd1);

    // rejected STEP_C in RUN, then HALT
    cmd(3'd3, 16'd0);
    #1;
    check("err_pulse", 32'(Cmd_Err), 32'd1);
    check("err_stay_run", 32'(Debug_Mode), 32'd1);
    cmd(3'd2, 16'd0);
    #1;
    check("halt_after_run", 32'(Halted), 32'd1);
    check("err_cleared", 32'(Cmd_Err), 32'd0);

    // saturation of the run counter, then CLR_CNT against an increment
    cmd(3'd6, 16'd0);
    cmd(3'd1, 16'd0);
    idle(65540);
    #1;
    check("count_saturate", 32'(Cycle_Count), 32'h0000FFFF);
    cmd(3'd7, 16'd0);
    #1;
    check("clr_over_inc", 32'(Cycle_Count), 32'd0);
    cmd(3'd2, 16'd0);

    // reset during RUN
    cmd(3'd1, 16'd0);
    idle(3);
    cycle(1'b1, 1'b1, 3'd1, 16'd0);
    #1;
    check("rst_mid_halted", 32'(Halted), 32'd1);
    check("rst_mid_count", 32'(Cycle_Count), 32'd0);

    // randomized phase
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 199);
      cycle(r == 0, r < 70, 3'($urandom_range(0, 7)),
            core_pc + 16'($urandom_range(0, 3)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
